// File: rtl/alu_exec.sv
// Registered ALU execute stage: single-cycle ADD/AND/OR/XOR plus a multi-cycle
// serial left shifter sharing one output register, with valid/ready on both sides.
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op0,
    input  logic             op1,
    input  logic             op2,
    input  logic             op3,
    input  logic             op4,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             n_flag
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             out_free;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             load_c;
    logic [WIDTH-1:0] b_mod;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] work_shl;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !rst && (state_q == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign b_mod    = op4 ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_mod} + {{WIDTH{1'b0}}, op2};
    assign work_shl = {work_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_val    = '0;
        load_c      = c_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op3) begin
                        if (b[2:0] == 3'd0) begin
                            load     = 1'b1;
                            load_val = a;
                        end else begin
                            work_d  = a;
                            cnt_d   = b[2:0];
                            state_d = S_SHIFT;
                        end
                    end else begin
                        load = 1'b1;
                        case ({op1, op0})
                            2'b00: begin
                                load_val = sum[WIDTH-1:0];
                                load_c   = sum[WIDTH];
                            end
                            2'b01:   load_val = a & b_mod;
                            2'b10:   load_val = a | b_mod;
                            default: load_val = a ^ b_mod;
                        endcase
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q > 3'd1) begin
                    work_d = work_shl;
                    cnt_d  = cnt_q - 3'd1;
                end else if (out_free) begin
                    // Final shift goes straight into the output register; the
                    // carry is the MSB being shifted out on this step.
                    load     = 1'b1;
                    load_val = work_shl;
                    load_c   = work_q[WIDTH-1];
                    work_d   = work_shl;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            result_d    = load_val;
            c_d         = load_c;
            z_d         = (load_val == '0);
            n_d         = load_val[WIDTH-1];
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign n_flag    = n_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios plus a randomized run scored against
// an arithmetic reference model with an in-order expected-result queue.
module tb_alu_exec;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op0, op1, op2, op3, op4;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_flag, z_flag, n_flag;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op0(op0), .op1(op1), .op2(op2), .op3(op3), .op4(op4),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag)
    );

    always #5 clk = ~clk;

    // ops packed as {op4, op3, op2, op1, op0}
    task automatic set_in(input logic v, input logic [4:0] ops,
                          input logic [W-1:0] aa, input logic [W-1:0] bb);
        in_valid = v;
        {op4, op3, op2, op1, op0} = ops;
        a = aa;
        b = bb;
    endtask

    // Reference: returns {c, z, n, r} computed with plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [4:0] ops,
                                           input logic [W-1:0] aa,
                                           input logic [W-1:0] bb,
                                           input logic cin);
        int unsigned t, bv, r;
        logic        c;
        c = cin;
        if (ops[3]) begin
            t = int'(aa) << bb[2:0];
            r = t % (1 << W);
            if (bb[2:0] != 0) c = ((t >> W) & 1) != 0;
        end else begin
            bv = ops[4] ? ((1 << W) - 1 - int'(bb)) : int'(bb);
            case (ops[1:0])
                2'b00: begin
                    t = int'(aa) + bv + (ops[2] ? 1 : 0);
                    r = t % (1 << W);
                    c = (t >= (1 << W));
                end
                2'b01:   r = int'(aa) & bv;
                2'b10:   r = int'(aa) | bv;
                default: r = int'(aa) ^ bv;
            endcase
        end
        model = {c, (r == 0), (r >= (1 << (W - 1))), r[W-1:0]};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 5'b00000, 8'hAA, 8'h55);
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, result, c_flag, z_flag, n_flag} !== 13'b0)
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h c=%b z=%b n=%b, want all 0",
                     in_ready, out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_add;
        set_in(1'b1, 5'b00000, 8'hF0, 8'h20);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h10, 3'b100})
            $display("FAIL add: got vld=%b res=%h czn=%b%b%b want 1 10 100",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
    endtask

    task automatic test_sub_and;
        set_in(1'b1, 5'b10100, 8'h05, 8'h05);
        @(negedge clk);
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h00, 3'b110})
            $display("FAIL sub: got vld=%b res=%h czn=%b%b%b want 1 00 110",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
        set_in(1'b1, 5'b00001, 8'hFF, 8'h80);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h80, 3'b101})
            $display("FAIL and_keeps_c: got vld=%b res=%h czn=%b%b%b want 1 80 101",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
    endtask

    task automatic test_shift;
        set_in(1'b1, 5'b01000, 8'h21, 8'h03);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total_cnt++;
            if ({in_ready, out_valid} !== 2'b00)
                $display("FAIL shift_busy[%0d]: got rdy=%b vld=%b want 0 0", i, in_ready, out_valid);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h08, 3'b100})
            $display("FAIL shift3: got vld=%b res=%h czn=%b%b%b want 1 08 100",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
        set_in(1'b1, 5'b01000, 8'h5A, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h5A, 3'b100})
            $display("FAIL shift0: got vld=%b res=%h czn=%b%b%b want 1 5a 100",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: got vld=%b want 0", out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
        set_in(1'b1, 5'b00000, 8'h10, 8'h01);
        @(negedge clk);
        set_in(1'b1, 5'b00000, 8'hFF, 8'h02);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total_cnt++;
            if ({in_ready, out_valid, result, c_flag, z_flag, n_flag} !== {2'b01, 8'h11, 3'b000})
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b res=%h czn=%b%b%b want 0 1 11 000",
                         i, in_ready, out_valid, result, c_flag, z_flag, n_flag);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_pulse_ready: got %b want 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            total_cnt++;
            if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h01, 3'b100})
                $display("FAIL bp_second[%0d]: got vld=%b res=%h czn=%b%b%b want 1 01 100",
                         i, out_valid, result, c_flag, z_flag, n_flag);
            else pass_cnt++;
        end
        // shift accepted on a drain edge, finishing while out_ready is low
        out_ready = 1'b1;
        set_in(1'b1, 5'b01000, 8'hC1, 8'h02);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_shift_start: got vld=%b want 0", out_valid);
        else pass_cnt++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({in_ready, out_valid, result, c_flag, z_flag, n_flag} !== {2'b01, 8'h04, 3'b100})
                $display("FAIL bp_shift_hold[%0d]: got rdy=%b vld=%b res=%h czn=%b%b%b want 0 1 04 100",
                         i, in_ready, out_valid, result, c_flag, z_flag, n_flag);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b0, 8'h04, 3'b100})
            $display("FAIL bp_flags_persist: got vld=%b res=%h czn=%b%b%b want 0 04 100",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift;
        out_ready = 1'b1;
        set_in(1'b1, 5'b01000, 8'hFF, 8'h07);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, result, c_flag, z_flag, n_flag} !== 13'b0)
            $display("FAIL midshift_reset: got rdy=%b vld=%b res=%h czn=%b%b%b want all 0",
                     in_ready, out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            total_cnt++;
            if ({in_ready, out_valid} !== 2'b10)
                $display("FAIL midshift_idle[%0d]: got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
            else pass_cnt++;
            @(negedge clk);
        end
        set_in(1'b1, 5'b00000, 8'h01, 8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, result, c_flag, z_flag, n_flag} !== {1'b1, 8'h02, 3'b000})
            $display("FAIL midshift_add: got vld=%b res=%h czn=%b%b%b want 1 02 000",
                     out_valid, result, c_flag, z_flag, n_flag);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [W+2:0] exp_q[$];
        logic [W+2:0] exp;
        logic [4:0]   ops;
        logic         c_m;
        int           budget;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        c_m = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ops = 5'($urandom);
            set_in($urandom_range(0, 9) < 7, ops, W'($urandom), W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_output: cyc %0d res=%h with nothing expected", cyc, result);
                end else begin
                    exp = exp_q.pop_front();
                    if ({c_flag, z_flag, n_flag, result} !== exp)
                        $display("FAIL rand_result: cyc %0d got czn=%b%b%b res=%h want czn=%b res=%h",
                                 cyc, c_flag, z_flag, n_flag, result, exp[W+2:W], exp[W-1:0]);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp = model(ops, a, b, c_m);
                c_m = exp[W+2];
                exp_q.push_back(exp);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 20;
        while ((exp_q.size() != 0) && (budget > 0)) begin
            #1;
            if (out_valid) begin
                total_cnt++;
                exp = exp_q.pop_front();
                if ({c_flag, z_flag, n_flag, result} !== exp)
                    $display("FAIL rand_tail: got czn=%b%b%b res=%h want czn=%b res=%h",
                             c_flag, z_flag, n_flag, result, exp[W+2:W], exp[W-1:0]);
                else pass_cnt++;
            end
            budget--;
            @(negedge clk);
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL rand_lost: %0d results never appeared, want 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 5'b00000, '0, '0);
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_and();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
